radix_digit_splitter: RTL



---
 rtl/digit_pkg.sv | 21 ++
 rtl/const_divmod.sv | 15 +
 rtl/radix_digit_splitter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/digit_pkg.sv
// Shared types and helpers for the radix digit splitter: FSM state encoding,
// the blank digit code and a constant power function for parameter checks.
package digit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic longint pow_radix(input int radix, input int digits);
        longint acc = 1;
        for (int i = 0; i < digits; i++) begin
            acc = acc * radix;
        end
        return acc;
    endfunction

endpackage

// File: rtl/const_divmod.sv
// Combinational quotient/remainder by a constant radix; one digit step of the
// splitter, reused every clock on the work register.
module const_divmod #(
    parameter int WIDTH = 13,
    parameter int RADIX = 10
) (
    input  logic [WIDTH-1:0]          dividend,
    output logic [WIDTH-1:0]          quotient,
    output logic [$clog2(RADIX)-1:0]  remainder
);

    assign quotient  = dividend / WIDTH'(RADIX);
    assign remainder = $clog2(RADIX)'(dividend % WIDTH'(RADIX));

endmodule

// File: rtl/radix_digit_splitter.sv
// Sequential binary-to-digit converter: one base-RADIX digit per clock, with
// start/done handshake, overflow saturation and optional leading-zero blanking.
module radix_digit_splitter
    import digit_pkg::*;
#(
    parameter int WIDTH         = 13,
    parameter int RADIX         = 10,
    parameter int DIGITS        = 4,
    parameter int DIGIT_W       = 4,
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Start,
    input  logic [WIDTH-1:0]            Input,
    output logic                        Busy,
    output logic                        Done,
    output logic [DIGITS*DIGIT_W-1:0]   Digits,
    output logic                        Overflow
);

    localparam int REM_W = $clog2(RADIX);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW    = DIGITS * DIGIT_W;

    if (RADIX < 2 || RADIX > 16) begin : g_bad_radix
        $error("RADIX must be in 2..16");
    end
    if (DIGIT_W < REM_W) begin : g_bad_digit_w
        $error("DIGIT_W too narrow for RADIX");
    end
    if (BLANK_LEADING && RADIX > 15) begin : g_bad_blank
        $error("BLANK_LEADING needs RADIX <= 15 so the blank code is not a digit");
    end
    if (DIGITS < 1 || pow_radix(RADIX, DIGITS) > (longint'(1) << 62)) begin : g_bad_digits
        $error("RADIX**DIGITS out of range");
    end

    state_t            state, next_state;
    logic [WIDTH-1:0]  work, quotient;
    logic [REM_W-1:0]  remainder;
    logic [CNT_W-1:0]  count;
    logic [DW-1:0]     scratch, staged, shown, saturated;
    logic              accept, last_step, seen;

    const_divmod #(
        .WIDTH (WIDTH),
        .RADIX (RADIX)
    ) u_divmod (
        .dividend  (work),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // A request is only taken when no conversion is running; DONE counts as free.
    assign accept    = Start && (state != DIVIDE);
    assign last_step = (state == DIVIDE) && (count == CNT_W'(DIGITS - 1));
    assign saturated = {DIGITS{DIGIT_W'(RADIX - 1)}};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = DIVIDE;
            DIVIDE:  if (last_step) next_state = DONE;
            DONE:    next_state = Start ? DIVIDE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == DIVIDE);
        Done = (state == DONE);
    end

    // Scratch with this step's remainder merged in, so the final digit is committed directly.
    always_comb begin
        staged = scratch;
        staged[int'(count) * DIGIT_W +: DIGIT_W] = DIGIT_W'(remainder);
    end

    // Blank zeros above the most significant nonzero digit; digit 0 always shows.
    always_comb begin
        shown = staged;
        seen  = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (!seen && staged[k * DIGIT_W +: DIGIT_W] == '0) begin
                if (BLANK_LEADING) shown[k * DIGIT_W +: DIGIT_W] = DIGIT_W'(BLANK_CODE);
            end else begin
                seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            count    <= '0;
            scratch  <= '0;
            Digits   <= '0;
            Overflow <= 1'b0;
        end else if (accept) begin
            work  <= Input;
            count <= '0;
        end else if (state == DIVIDE) begin
            work    <= quotient;
            scratch <= staged;
            if (last_step) begin
                Overflow <= (quotient != '0);
                Digits   <= (quotient != '0) ? saturated : shown;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
